// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;
  localparam int ADDR_W          = 30;
  localparam int OFFSET_W        = 2;
  localparam int BLOCK_ADDR_W    = ADDR_W - OFFSET_W;

  // Replace one 32-bit word of a block, leaving the other words intact.
  function automatic logic [BLOCK_W-1:0] merge_word(
    input logic [BLOCK_W-1:0]  blk,
    input logic [OFFSET_W-1:0] sel,
    input logic [WORD_W-1:0]   word
  );
    logic [BLOCK_W-1:0] result;
    result = blk;
    result[sel*WORD_W +: WORD_W] = word;
    return result;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for the data cache: combinational indexed read,
// single-word write and whole-block fill, cleared by the asynchronous reset.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = BLOCK_ADDR_W - INDEX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  index,
  output logic                line_valid,
  output logic                line_dirty,
  output logic [TAG_W-1:0]    line_tag,
  output logic [BLOCK_W-1:0]  line_data,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] word_sel,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  assign line_valid = valid_q[index];
  assign line_dirty = dirty_q[index];
  assign line_tag   = tag_q[index];
  assign line_data  = data_q[index];

  // Fill and word write never coincide: fill happens only in ALLOCATE,
  // word writes only on a COMPARE hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
      tag_q[index]   <= fill_tag;
      data_q[index]  <= fill_data;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
      data_q[index]  <= merge_word(data_q[index], word_sel, word_data);
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate D-cache with block-wide memory handshake.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3
) (
  input  logic                    clk,
  input  logic                    proc_reset,
  input  logic                    proc_read,
  input  logic                    proc_write,
  input  logic [ADDR_W-1:0]       proc_addr,
  input  logic [WORD_W-1:0]       proc_wdata,
  output logic                    proc_stall,
  output logic [WORD_W-1:0]       proc_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [BLOCK_ADDR_W-1:0] mem_addr,
  output logic [BLOCK_W-1:0]      mem_wdata,
  input  logic [BLOCK_W-1:0]      mem_rdata,
  input  logic                    mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int TAG_W = BLOCK_ADDR_W - INDEX_W;

  state_t state, next_state;

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic                active;
  logic                hit;
  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                word_we;
  logic                fill_we;

  assign offset = proc_addr[OFFSET_W-1:0];
  assign index  = proc_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign tag    = proc_addr[ADDR_W-1:INDEX_W+OFFSET_W];
  assign active = proc_read | proc_write;
  assign hit    = active & line_valid & (line_tag == tag);

  assign proc_stall = active & ((state != COMPARE) | ~hit);
  assign proc_rdata = line_data[offset*WORD_W +: WORD_W];

  // A write miss lands here too, on the re-compare after the fill.
  assign word_we = (state == COMPARE) & proc_write & hit;
  assign fill_we = (state == ALLOCATE) & mem_ready;

  dcache_line_array #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_lines (
    .clk       (clk),
    .rst       (proc_reset),
    .index     (index),
    .line_valid(line_valid),
    .line_dirty(line_dirty),
    .line_tag  (line_tag),
    .line_data (line_data),
    .word_we   (word_we),
    .word_sel  (offset),
    .word_data (proc_wdata),
    .fill_we   (fill_we),
    .fill_tag  (tag),
    .fill_data (mem_rdata)
  );

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) state <= COMPARE;
    else            state <= next_state;
  end

  // Memory outputs depend on state only; the victim stays stable in WRITEBACK
  // because the line array is not written until the fill.
  always_comb begin
    next_state = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      COMPARE: begin
        if (active && !hit)
          next_state = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {line_tag, index};
        mem_wdata = line_data;
        if (mem_ready) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = {tag, index};
        if (mem_ready) next_state = COMPARE;
      end
      default: next_state = COMPARE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic recompare;

  // The cycle right after a fill is a re-compare and is not a first-try hit.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      recompare  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      recompare <= fill_we;
      if (state == COMPARE && hit && !recompare)
        hit_count <= hit_count + 32'd1;
      if (state == COMPARE && next_state != COMPARE)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Directed self-checking bench for dcache_wb; each scenario task checks its own results.
module tb_dcache_wb;
  import dcache_pkg::*;

  localparam logic [127:0] BLK_A = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
  localparam logic [127:0] BLK_B = 128'h44440003_44440002_44440001_44440000;
  localparam logic [127:0] VICTIM = 128'h0000DDDD_12345678_0000BBBB_0000AAAA;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dcache_wb #(.INDEX_W(3)) dut (
    .clk       (clk),
    .proc_reset(proc_reset),
    .proc_read (proc_read),
    .proc_write(proc_write),
    .proc_addr (proc_addr),
    .proc_wdata(proc_wdata),
    .proc_stall(proc_stall),
    .proc_rdata(proc_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    step();
    step();
    checks++; if (proc_stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %0h expected 0", proc_stall); end
    checks++; if (mem_read !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_read: got %0h expected 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_write: got %0h expected 0", mem_write); end
    checks++; if (mem_addr !== 28'h0) begin fails++; $display("[TB] FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 128'h0) begin fails++; $display("[TB] FAIL reset_mem_wdata: got %0h expected 0", mem_wdata); end
`ifdef DCACHE_STATS_EN
    checks++; if (hit_count !== 32'd0) begin fails++; $display("[TB] FAIL reset_hit_count: got %0d expected 0", hit_count); end
    checks++; if (miss_count !== 32'd0) begin fails++; $display("[TB] FAIL reset_miss_count: got %0d expected 0", miss_count); end
`endif
    proc_reset = 1'b0;
    proc_read  = 1'b1;
    proc_addr  = 30'h0000010;
    #1;
    checks++; if (proc_stall !== 1'b1) begin fails++; $display("[TB] FAIL reset_first_read_stall: got %0h expected 1", proc_stall); end
  endtask

  // Line 4 is invalid: one COMPARE miss cycle, then three ALLOCATE cycles.
  task automatic test_clean_miss();
    int stall_cycles = 0;
    int alloc_cycles = 0;
    for (int c = 0; c < 40 && proc_stall === 1'b1; c++) begin
      stall_cycles++;
      checks++; if (mem_write !== 1'b0) begin fails++; $display("[TB] FAIL clean_miss_mem_write: got %0h expected 0", mem_write); end
      if (mem_read === 1'b1) begin
        alloc_cycles++;
        checks++; if (mem_addr !== 28'h4) begin fails++; $display("[TB] FAIL clean_miss_mem_addr: got %0h expected 4", mem_addr); end
        mem_rdata = BLK_A;
        mem_ready = (alloc_cycles == 3);
      end else begin
        mem_ready = 1'b0;
      end
      step();
    end
    mem_ready = 1'b0;
    checks++; if (proc_stall !== 1'b0) begin fails++; $display("[TB] FAIL clean_miss_timeout: stall got %0h expected 0", proc_stall); end
    checks++; if (stall_cycles != 4) begin fails++; $display("[TB] FAIL clean_miss_stall_cycles: got %0d expected 4", stall_cycles); end
    checks++; if (alloc_cycles != 3) begin fails++; $display("[TB] FAIL clean_miss_alloc_cycles: got %0d expected 3", alloc_cycles); end
    checks++; if (proc_rdata !== 32'h0000AAAA) begin fails++; $display("[TB] FAIL clean_miss_rdata: got %0h expected aaaa", proc_rdata); end
    proc_read = 1'b0;
    step();
  endtask

  task automatic test_read_hit();
    proc_read = 1'b1;
    proc_addr = 30'h0000011;
    #1;
    checks++; if (proc_stall !== 1'b0) begin fails++; $display("[TB] FAIL read_hit_stall: got %0h expected 0", proc_stall); end
    checks++; if (proc_rdata !== 32'h0000BBBB) begin fails++; $display("[TB] FAIL read_hit_rdata: got %0h expected bbbb", proc_rdata); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("[TB] FAIL read_hit_traffic: got rd=%0h wr=%0h expected 0 0", mem_read, mem_write); end
    step();
    proc_read = 1'b0;
  endtask

  task automatic test_write_hit();
    proc_write = 1'b1;
    proc_addr  = 30'h0000012;
    proc_wdata = 32'h12345678;
    #1;
    checks++; if (proc_stall !== 1'b0) begin fails++; $display("[TB] FAIL write_hit_stall: got %0h expected 0", proc_stall); end
    step();
    proc_write = 1'b0;
    proc_read  = 1'b1;
    #1;
    checks++; if (proc_rdata !== 32'h12345678) begin fails++; $display("[TB] FAIL write_hit_readback: got %0h expected 12345678", proc_rdata); end
    checks++; if (proc_stall !== 1'b0) begin fails++; $display("[TB] FAIL write_hit_readback_stall: got %0h expected 0", proc_stall); end
    step();
    proc_read = 1'b0;
  endtask

  // Same index, tag 8: the dirty line goes back first, then block 0x44 is fetched.
  task automatic test_dirty_miss();
    int stall_cycles = 0;
    int wb_cycles    = 0;
    int alloc_cycles = 0;
    proc_read = 1'b1;
    proc_addr = 30'h0000112;
    #1;
    for (int c = 0; c < 40 && proc_stall === 1'b1; c++) begin
      stall_cycles++;
      checks++; if (mem_read === 1'b1 && mem_write === 1'b1) begin fails++; $display("[TB] FAIL dirty_miss_both_req: got rd=1 wr=1 expected at most one"); end
      if (mem_write === 1'b1) begin
        wb_cycles++;
        checks++; if (mem_addr !== 28'h4) begin fails++; $display("[TB] FAIL dirty_miss_wb_addr: got %0h expected 4", mem_addr); end
        checks++; if (mem_wdata !== VICTIM) begin fails++; $display("[TB] FAIL dirty_miss_wb_data: got %0h expected %0h", mem_wdata, VICTIM); end
        mem_ready = (wb_cycles == 2);
      end else if (mem_read === 1'b1) begin
        alloc_cycles++;
        checks++; if (mem_addr !== 28'h44) begin fails++; $display("[TB] FAIL dirty_miss_alloc_addr: got %0h expected 44", mem_addr); end
        mem_rdata = BLK_B;
        mem_ready = (alloc_cycles == 3);
      end else begin
        mem_ready = 1'b0;
      end
      step();
    end
    mem_ready = 1'b0;
    checks++; if (proc_stall !== 1'b0) begin fails++; $display("[TB] FAIL dirty_miss_timeout: stall got %0h expected 0", proc_stall); end
    checks++; if (wb_cycles != 2) begin fails++; $display("[TB] FAIL dirty_miss_wb_cycles: got %0d expected 2", wb_cycles); end
    checks++; if (stall_cycles != 6) begin fails++; $display("[TB] FAIL dirty_miss_stall_cycles: got %0d expected 6", stall_cycles); end
    checks++; if (proc_rdata !== 32'h44440002) begin fails++; $display("[TB] FAIL dirty_miss_rdata: got %0h expected 44440002", proc_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    proc_read = 1'b1;
    proc_addr = 30'h0000113;
    #1;
    checks++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h44440003) begin fails++; $display("[TB] FAIL b2b_read_113: got stall=%0h data=%0h expected 0 44440003", proc_stall, proc_rdata); end
    step();
    proc_addr = 30'h0000111;
    #1;
    checks++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h44440001) begin fails++; $display("[TB] FAIL b2b_read_111: got stall=%0h data=%0h expected 0 44440001", proc_stall, proc_rdata); end
    step();
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_addr  = 30'h0000113;
    proc_wdata = 32'hCAFEF00D;
    #1;
    checks++; if (proc_stall !== 1'b0) begin fails++; $display("[TB] FAIL b2b_write_stall: got %0h expected 0", proc_stall); end
    step();
    proc_write = 1'b0;
    proc_read  = 1'b1;
    #1;
    checks++; if (proc_rdata !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL b2b_readback: got %0h expected cafef00d", proc_rdata); end
    step();
    proc_read = 1'b0;
`ifdef DCACHE_STATS_EN
    // First-try hits: 0x11, w0x12, 0x12, 0x113, 0x111, w0x113, 0x113.
    checks++; if (hit_count !== 32'd7) begin fails++; $display("[TB] FAIL stats_hit_count: got %0d expected 7", hit_count); end
    checks++; if (miss_count !== 32'd2) begin fails++; $display("[TB] FAIL stats_miss_count: got %0d expected 2", miss_count); end
`endif
  endtask

  task automatic test_reset_abort();
    proc_read = 1'b1;
    proc_addr = 30'h0000020;
    #1;
    checks++; if (proc_stall !== 1'b1) begin fails++; $display("[TB] FAIL abort_miss_stall: got %0h expected 1", proc_stall); end
    step();
    checks++; if (mem_read !== 1'b1 || mem_addr !== 28'h8) begin fails++; $display("[TB] FAIL abort_alloc: got rd=%0h addr=%0h expected 1 8", mem_read, mem_addr); end
    step();
    #2;
    proc_reset = 1'b1;
    #1;
    checks++; if (mem_read !== 1'b0 || mem_addr !== 28'h0) begin fails++; $display("[TB] FAIL abort_async_drop: got rd=%0h addr=%0h expected 0 0", mem_read, mem_addr); end
`ifdef DCACHE_STATS_EN
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin fails++; $display("[TB] FAIL abort_stats_clear: got %0d %0d expected 0 0", hit_count, miss_count); end
`endif
    step();
    proc_reset = 1'b0;
    proc_addr  = 30'h0000112;
    #1;
    checks++; if (proc_stall !== 1'b1 || mem_read !== 1'b0) begin fails++; $display("[TB] FAIL abort_remiss: got stall=%0h rd=%0h expected 1 0", proc_stall, mem_read); end
    proc_read = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
